et_bitstream_gen: RTL and testbench



---
 rtl/et_bitstream_gen.sv | 124 ++++++++++++
 tb/tb_et_bitstream_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/et_bitstream_gen.sv
// rtl/et_bitstream_gen.sv - early-termination correlated SC bitstream generator (shared don't-care mask)
module et_bitstream_gen #(
    parameter int W = 8,
    parameter int N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     Bxs [N-1:0],
    input  logic [W-1:0]     S,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     bs,
    output logic             out_last,
    output logic [W:0]       len
);

    localparam int CW = $clog2(W + 1);
    localparam int IW = $clog2(W);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    bx_r [N-1:0];
    logic [W-1:0]    m_r;
    logic [W-1:0]    cnt;
    logic [CW-1:0]   k_r;
    logic [CW-1:0]   k_in;
    logic [CW-1:0]   idx;
    logic [CW-1:0]   sel;
    logic [W-1:0]    r;
    logic            accept;
    logic            fire;
    logic            last_hit;

    // K = number of active (unmasked) positions in the incoming mask
    always_comb begin
        k_in = '0;
        for (int p = 0; p < W; p++) begin
            if (!S[p]) begin
                k_in = k_in + CW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                if (out_ready && last_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept   = in_valid & in_ready;
    assign fire     = out_valid & out_ready;
    assign last_hit = ({1'b0, cnt} == (len - (W+1)'(1)));
    assign out_last = (state == RUN) & last_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            m_r   <= '0;
            k_r   <= '0;
            len   <= '0;
            for (int j = 0; j < N; j++) begin
                bx_r[j] <= '0;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                for (int j = 0; j < N; j++) begin
                    bx_r[j] <= Bxs[j];
                end
                m_r <= S;
                k_r <= k_in;
                len <= (W+1)'(1) << k_in;
                cnt <= '0;
            end else if (fire) begin
                cnt <= last_hit ? '0 : cnt + W'(1);
            end
        end
    end

    // Van der Corput deposit: the i-th active position (from LSB) takes cnt[K-1-i],
    // so the counter LSB lands on the most significant active position.
    always_comb begin
        r   = '0;
        idx = '0;
        sel = '0;
        for (int p = 0; p < W; p++) begin
            if (!m_r[p]) begin
                sel  = k_r - CW'(1) - idx;
                r[p] = cnt[sel[IW-1:0]];
                idx  = idx + CW'(1);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            bs[j] = (bx_r[j] > r);
        end
    end

endmodule

// File: tb/tb_et_bitstream_gen.sv
// tb/tb_et_bitstream_gen.sv - scoreboard bench for et_bitstream_gen
module tb_et_bitstream_gen;

    localparam int W = 4;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  Bxs [N-1:0];
    logic [W-1:0]  S;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  bs;
    logic          out_last;
    logic [W:0]    len;

    et_bitstream_gen #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Bxs       (Bxs),
        .S         (S),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bs        (bs),
        .out_last  (out_last),
        .len       (len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] bs;
        logic         last;
        logic [W:0]   len;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt;
    int   run_cyc;
    int   ones [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] model_r(input int c, input logic [W-1:0] mask);
        int           pos [W];
        int           k;
        logic [W-1:0] rr;
        k  = 0;
        rr = '0;
        for (int p = 0; p < W; p++) begin
            if (!mask[p]) begin
                pos[k] = p;
                k++;
            end
        end
        for (int i = 0; i < k; i++) begin
            rr[pos[i]] = c[k-1-i];
        end
        return rr;
    endfunction

    task automatic push_exp(input logic [W-1:0] bx0, input logic [W-1:0] bx1, input logic [W-1:0] s);
        int           k;
        int           n;
        exp_t         x;
        logic [W-1:0] rr;
        k = 0;
        for (int p = 0; p < W; p++) begin
            if (!s[p]) k++;
        end
        n = 1 << k;
        for (int c = 0; c < n; c++) begin
            rr      = model_r(c, s);
            x.bs[0] = (bx0 > rr);
            x.bs[1] = (bx1 > rr);
            x.last  = (c == n - 1);
            x.len   = (W+1)'(n);
            exp_q.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            run_cyc++;
            if (out_ready) begin
                hs_cnt++;
                for (int j = 0; j < N; j++) ones[j] += int'(bs[j]);
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bs", 32'(bs), 32'(e.bs));
                    check("out_last", 32'(out_last), 32'(e.last));
                    check("len", 32'(len), 32'(e.len));
                end
            end else if (exp_q.size() > 0) begin
                check("stall_bs", 32'(bs), 32'(exp_q[0].bs));
                check("stall_last", 32'(out_last), 32'(exp_q[0].last));
            end
        end
    end

    task automatic start(input logic [W-1:0] bx0, input logic [W-1:0] bx1, input logic [W-1:0] s);
        @(negedge clk);
        Bxs[0]   = bx0;
        Bxs[1]   = bx1;
        S        = s;
        in_valid = 1'b1;
        hs_cnt   = 0;
        run_cyc  = 0;
        for (int j = 0; j < N; j++) ones[j] = 0;
        check("ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        push_exp(bx0, bx1, s);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_run(input int stall_after, input int stall_len, input int pulse_at);
        int  stalled;
        bit  done;
        stalled = 0;
        done    = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (hs_cnt == stall_after && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            if (hs_cnt == pulse_at && out_valid) begin
                in_valid = 1'b1;
                Bxs[0]   = 4'b1111;
                Bxs[1]   = 4'b1111;
                S        = 4'b0000;
                pulse_at = -1;
            end
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) check("run_timeout", 32'd0, 32'd1);
        check("ready_after", 32'(in_ready), 32'd1);
        check("valid_after", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Bxs[0]    = '0;
        Bxs[1]    = '0;
        S         = '0;
        hs_cnt    = 0;
        run_cyc   = 0;
        for (int j = 0; j < N; j++) ones[j] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_bs", 32'(bs), 32'd0);
        check("rst_len", 32'(len), 32'd0);
        rst = 1'b0;

        start(4'b0110, 4'b0010, 4'b1001);
        finish_run(-1, 0, -1);
        check("c1_cycles", run_cyc, 4);
        check("c1_hs", hs_cnt, 4);
        check("c1_ones0", ones[0], 3);
        check("c1_ones1", ones[1], 1);

        start(4'b1011, 4'b0101, 4'b0000);
        finish_run(-1, 0, -1);
        check("c2_cycles", run_cyc, 16);
        check("c2_ones0", ones[0], 11);
        check("c2_ones1", ones[1], 5);

        start(4'b0000, 4'b0000, 4'b1111);
        finish_run(-1, 0, -1);
        check("c3_cycles", run_cyc, 1);
        check("c3_ones0", ones[0], 0);

        start(4'b0110, 4'b0010, 4'b1001);
        finish_run(2, 3, -1);
        check("stall_cycles", run_cyc, 7);
        check("stall_hs", hs_cnt, 4);
        check("stall_ones0", ones[0], 3);
        check("stall_ones1", ones[1], 1);

        start(4'b0110, 4'b0010, 4'b1001);
        finish_run(-1, 0, 1);
        check("pulse_hs", hs_cnt, 4);
        check("pulse_ones0", ones[0], 3);
        check("pulse_ones1", ones[1], 1);

        start(4'b0110, 4'b0010, 4'b1001);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_bs", 32'(bs), 32'd0);
        check("mid_rst_len", 32'(len), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        exp_q.delete();

        start(4'b1011, 4'b0101, 4'b1001);
        finish_run(-1, 0, -1);
        check("post_rst_hs", hs_cnt, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
